mesh_router_rr: RTL and testbench

MESH_ROUTER_RR -- requirements
Module: mesh_router_rr

---
 rtl/mesh_router_rr_if.sv | 26 ++
 rtl/mesh_router_rr.sv | 210 +++++++++++++++++++++
 tb/tb_mesh_router_rr.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_router_rr_if.sv
// Port bundle between a mesh router and its five neighbours (self, N, S, E, W).
// Messages are packed per port; fifo_count reports per-port input FIFO occupancy.
interface mesh_router_rr_if #(
   parameter int MSG_WIDTH  = 64,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [5*MSG_WIDTH-1:0] in_value;
   logic [4:0]             in_valid;
   logic [4:0]             in_ready;
   logic [5*MSG_WIDTH-1:0] out_value;
   logic [4:0]             out_valid;
   logic [4:0]             out_ready;
   logic [5*CNT_W-1:0]     fifo_count;

   modport slave (
      input  in_value, in_valid, out_ready,
      output in_ready, out_value, out_valid, fifo_count
   );

   modport master (
      output in_value, in_valid, out_ready,
      input  in_ready, out_value, out_valid, fifo_count
   );
endinterface

// File: rtl/mesh_router_rr.sv
// Five-port mesh router: FWFT input FIFOs, one round-robin arbiter, XY unicast
// routing and a neighbour broadcast engine feeding registered output slots.
module mesh_router_rr #(
   parameter int MSG_WIDTH       = 64,
   parameter int CORDINATE_WIDTH = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int GRID_ROWS       = 8,
   parameter int GRID_COLS       = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CORDINATE_WIDTH-1:0] ROW_ID,
   input  logic [CORDINATE_WIDTH-1:0] COL_ID,
   mesh_router_rr_if.slave            bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CW    = CORDINATE_WIDTH;
   localparam int PAY_W = MSG_WIDTH - 2 * CW;

   localparam logic [2:0] P_SELF = 3'd0;
   localparam logic [2:0] P_N    = 3'd1;
   localparam logic [2:0] P_S    = 3'd2;
   localparam logic [2:0] P_E    = 3'd3;
   localparam logic [2:0] P_W    = 3'd4;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CW-1:0]    LAST_ROW = CW'(GRID_ROWS - 1);
   localparam logic [CW-1:0]    LAST_COL = CW'(GRID_COLS - 1);

   typedef enum logic {IDLE, BCAST} state_t;

   logic [MSG_WIDTH-1:0] mem_q [5][FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q [5];
   logic [PTR_W-1:0]     wr_ptr_q [5];
   logic [CNT_W-1:0]     cnt_q [5];
   logic [MSG_WIDTH-1:0] out_val_q [5];
   logic [MSG_WIDTH-1:0] out_val_d [5];
   logic [4:0]           out_vld_q, out_vld_d;
   logic [2:0]           rr_q, rr_d;
   logic [2:0]           bc_port_q, bc_port_d;
   logic [4:0]           pend_q, pend_d;
   state_t               state_q, state_d;

   logic [4:0]           nonempty, free, push, pop, load, bc_req;
   logic                 grant_vld;
   logic [2:0]           grant, uni_dir;
   logic [MSG_WIDTH-1:0] head;
   logic [CW-1:0]        dst_row, dst_col;
   logic [PAY_W-1:0]     payload;
   logic                 is_bcast;
   logic [MSG_WIDTH-1:0] bc_msg [5];

   function automatic logic [2:0] next_port(input logic [2:0] p);
      return (p == 3'd4) ? 3'd0 : p + 3'd1;
   endfunction

   always_comb begin
      nonempty = '0;
      free     = '0;
      for (int p = 0; p < 5; p++) begin
         nonempty[p] = (cnt_q[p] != '0);
         free[p]     = ~out_vld_q[p] | bus.out_ready[p];
      end
   end

   // A full FIFO whose head leaves this cycle can take a new word in the same cycle.
   always_comb begin
      bus.in_ready = '0;
      for (int p = 0; p < 5; p++) begin
         bus.in_ready[p] = (cnt_q[p] != FULL_CNT) | pop[p];
      end
      push = bus.in_valid & bus.in_ready;
   end

   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant     = bc_port_q;
      if (state_q == BCAST) begin
         grant_vld = 1'b1;
      end else begin
         // Scan from the far end so the port nearest the pointer wins last.
         for (int k = 4; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= 5) idx = idx - 5;
            if (nonempty[idx]) begin
               grant_vld = 1'b1;
               grant     = 3'(idx);
            end
         end
      end
   end

   always_comb begin
      head     = mem_q[grant][rd_ptr_q[grant]];
      dst_row  = head[MSG_WIDTH-1 -: CW];
      dst_col  = head[MSG_WIDTH-CW-1 -: CW];
      payload  = head[PAY_W-1:0];
      is_bcast = &dst_row;

      if (dst_row == ROW_ID && dst_col == COL_ID) uni_dir = P_SELF;
      else if (dst_row < ROW_ID)                  uni_dir = P_N;
      else if (dst_row > ROW_ID)                  uni_dir = P_S;
      else if (dst_col > COL_ID)                  uni_dir = P_E;
      else                                        uni_dir = P_W;

      bc_req      = '0;
      bc_req[P_N] = dst_col[3] && (ROW_ID != '0);
      bc_req[P_E] = dst_col[2] && (COL_ID != LAST_COL);
      bc_req[P_W] = dst_col[1] && (COL_ID != '0);
      bc_req[P_S] = dst_col[0] && (ROW_ID != LAST_ROW);

      for (int p = 0; p < 5; p++) bc_msg[p] = head;
      bc_msg[P_N] = {ROW_ID - CW'(1), COL_ID, payload};
      bc_msg[P_S] = {ROW_ID + CW'(1), COL_ID, payload};
      bc_msg[P_E] = {ROW_ID, COL_ID + CW'(1), payload};
      bc_msg[P_W] = {ROW_ID, COL_ID - CW'(1), payload};
   end

   always_comb begin
      out_val_d = out_val_q;
      out_vld_d = out_vld_q & ~bus.out_ready;
      load      = '0;
      pop       = '0;
      rr_d      = rr_q;
      state_d   = state_q;
      pend_d    = pend_q;
      bc_port_d = bc_port_q;

      if (grant_vld) begin
         if (state_q == BCAST) begin
            load   = pend_q & free;
            pend_d = pend_q & ~free;
            if (pend_d == '0) begin
               pop[grant] = 1'b1;
               rr_d       = next_port(grant);
               state_d    = IDLE;
            end
         end else if (is_bcast) begin
            // An all-suppressed broadcast falls through here and is simply dropped.
            load = bc_req & free;
            if ((bc_req & ~free) == '0) begin
               pop[grant] = 1'b1;
               rr_d       = next_port(grant);
            end else begin
               pend_d    = bc_req & ~free;
               bc_port_d = grant;
               state_d   = BCAST;
            end
         end else if (free[uni_dir]) begin
            load[uni_dir] = 1'b1;
            pop[grant]    = 1'b1;
            rr_d          = next_port(grant);
         end
      end

      for (int p = 0; p < 5; p++) begin
         if (load[p]) begin
            out_val_d[p] = is_bcast ? bc_msg[p] : head;
            out_vld_d[p] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 5; p++) begin
            rd_ptr_q[p]  <= '0;
            wr_ptr_q[p]  <= '0;
            cnt_q[p]     <= '0;
            out_val_q[p] <= '0;
         end
         out_vld_q <= '0;
         rr_q      <= '0;
         bc_port_q <= '0;
         pend_q    <= '0;
         state_q   <= IDLE;
      end else begin
         for (int p = 0; p < 5; p++) begin
            if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(1);
            if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
            cnt_q[p]     <= cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            out_val_q[p] <= out_val_d[p];
         end
         out_vld_q <= out_vld_d;
         rr_q      <= rr_d;
         bc_port_q <= bc_port_d;
         pend_q    <= pend_d;
         state_q   <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 5; p++) begin
         if (push[p]) mem_q[p][wr_ptr_q[p]] <= bus.in_value[p*MSG_WIDTH +: MSG_WIDTH];
      end
   end

   always_comb begin
      bus.out_value  = '0;
      bus.fifo_count = '0;
      for (int p = 0; p < 5; p++) begin
         bus.out_value[p*MSG_WIDTH +: MSG_WIDTH] = out_val_q[p];
         bus.fifo_count[p*CNT_W +: CNT_W]        = cnt_q[p];
      end
      bus.out_valid = out_vld_q;
   end
endmodule

// File: tb/tb_mesh_router_rr.sv
// Directed scoreboard bench for mesh_router_rr: expected outputs are queued per
// output port when a write is accepted and compared when the router emits them.
module tb_mesh_router_rr;
   localparam int MW   = 64;
   localparam int CW   = 4;
   localparam int FD   = 4;
   localparam int GR   = 8;
   localparam int GC   = 8;
   localparam int CNTW = $clog2(FD) + 1;
   localparam int PW   = MW - 2 * CW;

   logic          clk = 1'b0;
   logic          reset;
   logic [CW-1:0] row_id, col_id;

   mesh_router_rr_if #(.MSG_WIDTH(MW), .FIFO_DEPTH(FD)) bus ();

   mesh_router_rr #(
      .MSG_WIDTH(MW), .CORDINATE_WIDTH(CW), .FIFO_DEPTH(FD),
      .GRID_ROWS(GR), .GRID_COLS(GC)
   ) dut (
      .clk(clk), .reset(reset), .ROW_ID(row_id), .COL_ID(col_id), .bus(bus)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_out [5];
   logic [MW-1:0] exp_q [5][$];
   logic [4:0]    hold_prev;
   logic [MW-1:0] prev_val [5];

   function automatic logic [MW-1:0] mk(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                        input logic [PW-1:0] pay);
      return {r, c, pay};
   endfunction

   function automatic logic [MW-1:0] ov(input int p);
      return bus.out_value[p*MW +: MW];
   endfunction

   function automatic logic [MW-1:0] fc(input int p);
      return MW'(bus.fifo_count[p*CNTW +: CNTW]);
   endfunction

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference routing: where an accepted message must come out, and as what.
   task automatic expect_for(input logic [MW-1:0] m);
      logic [CW-1:0] r, c;
      logic [PW-1:0] pay;
      r   = m[MW-1 -: CW];
      c   = m[MW-CW-1 -: CW];
      pay = m[PW-1:0];
      if (r == 4'hF) begin
         if (c[3] && row_id != 4'd0)      exp_q[1].push_back(mk(row_id - 4'd1, col_id, pay));
         if (c[0] && row_id != 4'(GR-1))  exp_q[2].push_back(mk(row_id + 4'd1, col_id, pay));
         if (c[2] && col_id != 4'(GC-1))  exp_q[3].push_back(mk(row_id, col_id + 4'd1, pay));
         if (c[1] && col_id != 4'd0)      exp_q[4].push_back(mk(row_id, col_id - 4'd1, pay));
      end else if (r == row_id && c == col_id) exp_q[0].push_back(m);
      else if (r < row_id)                     exp_q[1].push_back(m);
      else if (r > row_id)                     exp_q[2].push_back(m);
      else if (c > col_id)                     exp_q[3].push_back(m);
      else                                     exp_q[4].push_back(m);
   endtask

   task automatic tick();
      @(negedge clk);
      for (int p = 0; p < 5; p++) begin
         if (bus.in_valid[p] && bus.in_ready[p]) expect_for(bus.in_value[p*MW +: MW]);
      end
      for (int p = 0; p < 5; p++) begin
         if (hold_prev[p]) begin
            check($sformatf("hold_vld%0d", p), MW'(bus.out_valid[p]), MW'(1));
            check($sformatf("hold_val%0d", p), ov(p), prev_val[p]);
         end
         if (bus.out_valid[p] && bus.out_ready[p]) begin
            n_out[p]++;
            n_cmp++;
            assert (exp_q[p].size() != 0) else begin
               n_bad++;
               $error("FAIL out%0d_unexpected: observed %0h expected nothing", p, ov(p));
            end
            if (exp_q[p].size() != 0) check($sformatf("out%0d", p), ov(p), exp_q[p].pop_front());
         end
         hold_prev[p] = bus.out_valid[p] && !bus.out_ready[p];
         prev_val[p]  = ov(p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int p, input logic [MW-1:0] m);
      bus.in_value[p*MW +: MW] = m;
      bus.in_valid             = 5'(1 << p);
      tick();
      bus.in_valid             = '0;
   endtask

   task automatic do_reset(input logic [CW-1:0] r, input logic [CW-1:0] c);
      row_id       = r;
      col_id       = c;
      bus.in_valid = '0;
      reset        = 1'b1;
      for (int p = 0; p < 5; p++) exp_q[p].delete();
      hold_prev = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      logic [MW-1:0] m, b0, b1;
      int n0, tot;
      reset         = 1'b0;
      row_id        = 4'd2;
      col_id        = 4'd2;
      bus.in_value  = '0;
      bus.in_valid  = '0;
      bus.out_ready = '1;
      hold_prev     = '0;
      for (int p = 0; p < 5; p++) n_out[p] = 0;
      #1 reset = 1'b1;
      #1;
      check("rst_out_valid", MW'(bus.out_valid), '0);
      for (int p = 0; p < 5; p++) check($sformatf("rst_out_value%0d", p), ov(p), '0);
      check("rst_in_ready", MW'(bus.in_ready), MW'(5'b11111));
      check("rst_fifo_count", MW'(bus.fifo_count), '0);
      tick();
      reset = 1'b0;
      tick();

      // Unicast to north from the east input: one-cycle latency, value unchanged.
      m = mk(4'd1, 4'd5, 56'hA1);
      wr(3, m);
      check("r31_cnt_wr", fc(3), MW'(1));
      check("r31_ov_pre", MW'(bus.out_valid), '0);
      tick();
      check("r31_ov_north", MW'(bus.out_valid), MW'(5'b00010));
      check("r31_val", ov(1), m);
      check("r31_cnt_pop", fc(3), '0);

      // Simultaneous unicasts to south, east, west and self.
      bus.in_value[0*MW +: MW] = mk(4'd4, 4'd0, 56'hB0);
      bus.in_value[1*MW +: MW] = mk(4'd2, 4'd7, 56'hB1);
      bus.in_value[2*MW +: MW] = mk(4'd2, 4'd0, 56'hB2);
      bus.in_value[4*MW +: MW] = mk(4'd2, 4'd2, 56'hB4);
      bus.in_valid = 5'b10111;
      tick();
      bus.in_valid = '0;
      repeat (6) tick();
      check("uni_drained", MW'(bus.fifo_count), '0);

      // Interior broadcast requesting east and south.
      m = mk(4'hF, 4'b0101, 56'hC5);
      wr(2, m);
      tick();
      check("bc_int_ov", MW'(bus.out_valid), MW'(5'b01100));
      check("bc_int_east", ov(3), mk(4'd2, 4'd3, 56'hC5));
      check("bc_int_south", ov(2), mk(4'd3, 4'd2, 56'hC5));
      tick();

      // Round-robin from reset: ports 1, 2, 4 to self, then port 0 leads.
      do_reset(4'd2, 4'd2);
      bus.in_value[1*MW +: MW] = mk(4'd2, 4'd2, 56'hD1);
      bus.in_value[2*MW +: MW] = mk(4'd2, 4'd2, 56'hD2);
      bus.in_value[4*MW +: MW] = mk(4'd2, 4'd2, 56'hD4);
      bus.in_valid = 5'b10110;
      tick();
      bus.in_valid = '0;
      tick();
      check("rr_first", ov(0), mk(4'd2, 4'd2, 56'hD1));
      check("rr_first_vld", MW'(bus.out_valid), MW'(5'b00001));
      tick();
      check("rr_second", ov(0), mk(4'd2, 4'd2, 56'hD2));
      tick();
      check("rr_third", ov(0), mk(4'd2, 4'd2, 56'hD4));
      tick();
      b0 = mk(4'd2, 4'd2, 56'hE0);
      b1 = mk(4'd2, 4'd2, 56'hE1);
      bus.in_value[0*MW +: MW] = b0;
      bus.in_value[1*MW +: MW] = b1;
      bus.in_valid = 5'b00011;
      tick();
      bus.in_valid = '0;
      tick();
      check("rr_wrap_p0", ov(0), b0);
      tick();
      check("rr_wrap_p1", ov(0), b1);
      tick();

      // Backpressure on self: holding register plus FIFO_DEPTH entries, extra write dropped.
      bus.out_ready = 5'b11110;
      for (int k = 0; k < FD + 2; k++) begin
         bus.in_value[1*MW +: MW] = mk(4'd2, 4'd2, 56'h300 + 56'(k));
         bus.in_valid = 5'b00010;
         tick();
         check($sformatf("full_rdy%0d", k), MW'(bus.in_ready[1]), MW'(k < FD));
      end
      bus.in_valid = '0;
      check("full_cnt", fc(1), MW'(FD));
      n0 = n_out[0];
      bus.out_ready = '1;
      repeat (10) tick();
      check("full_drain", MW'(n_out[0] - n0), MW'(FD + 1));

      // Edge node (0,3): north suppressed, east blocked behind a held unicast.
      do_reset(4'd0, 4'd3);
      bus.out_ready = 5'b10111;
      m = mk(4'd0, 4'd5, 56'hF1);
      wr(0, m);
      tick();
      check("bc_pre_east", MW'(bus.out_valid), MW'(5'b01000));
      wr(0, mk(4'hF, 4'hF, 56'hF2));
      check("bc_cnt_wr", fc(0), MW'(1));
      tick();
      check("bc_partial_ov", MW'(bus.out_valid), MW'(5'b11100));
      check("bc_south", ov(2), mk(4'd1, 4'd3, 56'hF2));
      check("bc_west", ov(4), mk(4'd0, 4'd2, 56'hF2));
      check("bc_held_cnt", fc(0), MW'(1));
      tick();
      check("bc_wait_ov", MW'(bus.out_valid), MW'(5'b01000));
      check("bc_wait_cnt", fc(0), MW'(1));
      check("bc_wait_east", ov(3), m);
      bus.out_ready = '1;
      tick();
      check("bc_done_ov", MW'(bus.out_valid), MW'(5'b01000));
      check("bc_east", ov(3), mk(4'd0, 4'd4, 56'hF2));
      check("bc_done_cnt", fc(0), '0);
      tick();

      // Broadcast whose only request is suppressed is dropped silently.
      wr(0, mk(4'hF, 4'b1000, 56'hF3));
      check("bc_null_cnt_wr", fc(0), MW'(1));
      tick();
      check("bc_null_cnt", fc(0), '0);
      check("bc_null_ov", MW'(bus.out_valid), '0);
      tick();

      // Reset in the middle of a broadcast discards it entirely.
      bus.out_ready = 5'b10111;
      wr(0, mk(4'd0, 4'd5, 56'hF4));
      tick();
      wr(0, mk(4'hF, 4'hF, 56'hF5));
      tick();
      check("rbc_pending_cnt", fc(0), MW'(1));
      #2 reset = 1'b1;
      #1;
      check("rbc_ov", MW'(bus.out_valid), '0);
      check("rbc_east_val", ov(3), '0);
      check("rbc_in_ready", MW'(bus.in_ready), MW'(5'b11111));
      check("rbc_cnt", MW'(bus.fifo_count), '0);
      for (int p = 0; p < 5; p++) exp_q[p].delete();
      hold_prev = '0;
      tot = n_out[0] + n_out[1] + n_out[2] + n_out[3] + n_out[4];
      @(negedge clk);
      reset         = 1'b0;
      bus.out_ready = '1;
      @(posedge clk);
      #1;
      repeat (6) tick();
      check("rbc_no_residue", MW'(n_out[0] + n_out[1] + n_out[2] + n_out[3] + n_out[4]), MW'(tot));
      check("rbc_ov_after", MW'(bus.out_valid), '0);

      for (int p = 0; p < 5; p++) check($sformatf("left_in_q%0d", p), MW'(exp_q[p].size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
